// File: rtl/bcd2bin_arbiter.sv
// Four-requester round-robin arbiter that shares one bcd2bin converter.
// Define BCD2BIN_ARB_CHECK_EN to reject words with a nibble above 9 via err instead of converting them.
module bcd2bin_arbiter #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [63:0]  bcd_in,
    output logic [3:0]   ack,
    output logic [3:0]   err,
    output logic [3:0]   grant,
    output logic [W-1:0] bin_out,
    output logic         conv_start,
    output logic [3:0]   conv_bcd0,
    output logic [3:0]   conv_bcd1,
    output logic [3:0]   conv_bcd2,
    output logic [3:0]   conv_bcd3,
    input  logic         conv_ready,
    input  logic         conv_done_tick,
    input  logic [W-1:0] conv_bin
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        DONE
    } state_t;

    state_t      state;
    logic [1:0]  ptr;
    logic [1:0]  gidx;
    logic [1:0]  sel_idx;
    logic        sel_valid;
    logic [15:0] sel_word;
    logic        take_err;

    // Scan from ptr upward so the most recently served requester has lowest priority.
    always_comb begin
        logic [1:0] idx;
        sel_idx   = ptr;
        sel_valid = 1'b0;
        idx       = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                sel_idx   = idx;
                sel_valid = 1'b1;
            end
        end
    end

    assign sel_word = bcd_in[{sel_idx, 4'b0000} +: 16];

`ifdef BCD2BIN_ARB_CHECK_EN
    assign take_err = (sel_word[3:0]   > 4'd9) || (sel_word[7:4]   > 4'd9) ||
                      (sel_word[11:8]  > 4'd9) || (sel_word[15:12] > 4'd9);
`else
    assign take_err = 1'b0;
    assign err      = 4'b0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            gidx       <= 2'd0;
            grant      <= 4'b0000;
            ack        <= 4'b0000;
            conv_start <= 1'b0;
            bin_out    <= '0;
            conv_bcd0  <= 4'd0;
            conv_bcd1  <= 4'd0;
            conv_bcd2  <= 4'd0;
            conv_bcd3  <= 4'd0;
`ifdef BCD2BIN_ARB_CHECK_EN
            err        <= 4'b0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (conv_ready && sel_valid) begin
                        gidx  <= sel_idx;
                        grant <= 4'b0001 << sel_idx;
                        if (take_err) begin
`ifdef BCD2BIN_ARB_CHECK_EN
                            err <= 4'b0001 << sel_idx;
`endif
                            state <= DONE;
                        end else begin
                            conv_bcd0  <= sel_word[3:0];
                            conv_bcd1  <= sel_word[7:4];
                            conv_bcd2  <= sel_word[11:8];
                            conv_bcd3  <= sel_word[15:12];
                            conv_start <= 1'b1;
                            state      <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    conv_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (conv_done_tick) begin
                        bin_out <= conv_bin;
                        ack     <= 4'b0001 << gidx;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    ack   <= 4'b0000;
                    grant <= 4'b0000;
                    ptr   <= gidx + 2'd1;
`ifdef BCD2BIN_ARB_CHECK_EN
                    err   <= 4'b0000;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Scoreboard bench for bcd2bin_arbiter with a behavioural converter and a round-robin order model.
// Honours BCD2BIN_ARB_CHECK_EN so the same bench covers both builds.
module tb_bcd2bin_arbiter;
    localparam int W = 14;
`ifdef BCD2BIN_ARB_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [63:0]  bcd_in;
    logic [3:0]   ack;
    logic [3:0]   err;
    logic [3:0]   grant;
    logic [W-1:0] bin_out;
    logic         conv_start;
    logic [3:0]   conv_bcd0, conv_bcd1, conv_bcd2, conv_bcd3;
    logic         conv_ready;
    logic         conv_done_tick;
    logic [W-1:0] conv_bin;

    bcd2bin_arbiter #(.W(W)) dut (
        .clk(clk), .reset(reset), .req(req), .bcd_in(bcd_in),
        .ack(ack), .err(err), .grant(grant), .bin_out(bin_out),
        .conv_start(conv_start), .conv_bcd0(conv_bcd0), .conv_bcd1(conv_bcd1),
        .conv_bcd2(conv_bcd2), .conv_bcd3(conv_bcd3), .conv_ready(conv_ready),
        .conv_done_tick(conv_done_tick), .conv_bin(conv_bin)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           idx;
        bit           is_err;
        logic [W-1:0] val;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    int           model_ptr = 0;
    logic [W-1:0] model_bin = '0;
    logic [3:0]   pending = 4'b0000;

    function automatic logic [W-1:0] bcd_value(input logic [15:0] wd);
        int v;
        v = int'(wd[15:12]) * 1000 + int'(wd[11:8]) * 100 + int'(wd[7:4]) * 10 + int'(wd[3:0]);
        return v[W-1:0];
    endfunction

    function automatic bit bad_word(input logic [15:0] wd);
        bit b;
        b = 1'b0;
        for (int n = 0; n < 4; n++)
            if (wd[n*4 +: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] wd;
        int          pos;
        for (int n = 0; n < 4; n++) wd[n*4 +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) begin
            pos = $urandom_range(0, 3);
            wd[pos*4 +: 4] = 4'($urandom_range(10, 15));
        end
        return wd;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Stand-in converter: random latency, garbage on conv_bin except in the done cycle, stray ticks when idle.
    logic         busy = 1'b0;
    logic         ready_rand = 1'b1;
    int           cnt = 0;
    logic [W-1:0] cval = '0;
    assign conv_ready = !busy && ready_rand;

    always @(posedge clk) begin
        conv_done_tick <= 1'b0;
        conv_bin       <= W'($urandom);
        ready_rand     <= ($urandom_range(0, 3) != 0);
        if (busy) begin
            if (cnt == 0) begin
                conv_done_tick <= 1'b1;
                conv_bin       <= cval;
                busy           <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end else if (conv_start) begin
            busy <= 1'b1;
            cnt  <= $urandom_range(0, 3);
            cval <= bcd_value({conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0});
        end else if ($urandom_range(0, 15) == 0) begin
            conv_done_tick <= 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every ack/err and checks selection only happens when the converter is ready.
    initial begin
        exp_t       e;
        int         start_cnt;
        logic       prev_ready;
        logic [3:0] prev_grant;
        start_cnt  = 0;
        prev_ready = 1'b0;
        prev_grant = 4'b0000;
        forever begin
            @(negedge clk);
            if (reset) begin
                start_cnt  = 0;
                prev_grant = 4'b0000;
            end else begin
                if (conv_start) start_cnt++;
                if (prev_grant == 4'b0000 && grant != 4'b0000)
                    check_output("select_needs_ready", 64'(prev_ready), 64'd1);
                if ((ack | err) != 4'b0000) begin
                    check_output("ack_err_onehot", 64'($countones(ack | err)), 64'd1);
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_response: ack=%b err=%b with nothing outstanding", ack, err);
                    end else begin
                        e = sb.pop_front();
                        check_output("ack_vec", 64'(ack), e.is_err ? 64'd0 : 64'(4'b0001 << e.idx));
                        check_output("err_vec", 64'(err), e.is_err ? 64'(4'b0001 << e.idx) : 64'd0);
                        check_output("grant_held", 64'(grant), 64'(4'b0001 << e.idx));
                        check_output("bin_out", 64'(bin_out), 64'(e.val));
                        check_output("start_pulses", 64'(start_cnt), e.is_err ? 64'd0 : 64'd1);
                    end
                    start_cnt = 0;
                end
                prev_ready = conv_ready;
                prev_grant = grant;
            end
        end
    end

    // Issues one batch; the model predicts service order as the set bits taken cyclically from the pointer.
    task automatic apply_stimulus(input logic [3:0] mask, input logic [15:0] w0, input logic [15:0] w1,
                                  input logic [15:0] w2, input logic [15:0] w3, input bit scramble);
        logic [15:0] wv[4];
        exp_t        e;
        int          last;
        int          cyc;
        int          i;
        wv   = '{w0, w1, w2, w3};
        last = model_ptr;
        for (int k = 0; k < 4; k++) begin
            i = (model_ptr + k) % 4;
            if (mask[i]) begin
                e.idx = i;
                if (CHECK && bad_word(wv[i])) begin
                    e.is_err = 1'b1;
                    e.val    = model_bin;
                end else begin
                    e.is_err  = 1'b0;
                    e.val     = bcd_value(wv[i]);
                    model_bin = e.val;
                end
                sb.push_back(e);
                last = i;
            end
        end
        model_ptr = (last + 1) % 4;
        @(negedge clk);
        bcd_in  = {wv[3], wv[2], wv[1], wv[0]};
        req     = mask;
        pending = mask;
        cyc     = 0;
        while (pending != 4'b0000 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            for (int j = 0; j < 4; j++) begin
                if (ack[j] || err[j]) begin
                    pending[j] = 1'b0;
                    req[j]     = 1'b0;
                end else if (grant[j] && scramble) begin
                    bcd_in[j*16 +: 16] = 16'($urandom);
                    if ($urandom_range(0, 1) == 1) req[j] = 1'b0;
                end
            end
        end
        if (pending != 4'b0000) begin
            tests++;
            fails++;
            $display("[TB] FAIL batch_timeout: pending=%b, expected 0000", pending);
            sb.delete();
            req     = 4'b0000;
            pending = 4'b0000;
        end
    endtask

    // Reset lands while the converter is busy; its late tick must not produce an ack.
    task automatic reset_mid_wait();
        int cyc;
        @(negedge clk);
        bcd_in[15:0] = 16'h0042;
        req          = 4'b0001;
        cyc          = 0;
        while (!conv_start && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_output("launch_seen", 64'(conv_start), 64'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("rst_ack", 64'(ack), 64'd0);
        check_output("rst_grant", 64'(grant), 64'd0);
        check_output("rst_bin_out", 64'(bin_out), 64'd0);
        check_output("rst_conv_bcd0", 64'(conv_bcd0), 64'd0);
        check_output("rst_conv_start", 64'(conv_start), 64'd0);
        req       = 4'b0000;
        model_ptr = 0;
        model_bin = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        repeat (8) @(negedge clk);
        check_output("post_rst_grant", 64'(grant), 64'd0);
        check_output("post_rst_bin_out", 64'(bin_out), 64'd0);
    endtask

    initial begin
        int mask;
        reset  = 1'b1;
        req    = 4'b0000;
        bcd_in = '0;
        #1;
        check_output("init_grant", 64'(grant), 64'd0);
        check_output("init_ack", 64'(ack), 64'd0);
        check_output("init_err", 64'(err), 64'd0);
        check_output("init_start", 64'(conv_start), 64'd0);
        check_output("init_bin_out", 64'(bin_out), 64'd0);
        check_output("init_conv_bcd", 64'({conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0}), 64'd0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        apply_stimulus(4'b1111, 16'h0001, 16'h0010, 16'h0100, 16'h9999, 1'b0);
        apply_stimulus(4'b0001, 16'h0019, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        apply_stimulus(4'b0010, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 1'b0);
        apply_stimulus(4'b0011, 16'h0007, 16'h0008, 16'h0000, 16'h0000, 1'b0);
        apply_stimulus(4'b0100, 16'h0000, 16'h0000, 16'h0321, 16'h0000, 1'b0);
        apply_stimulus(4'b1001, 16'h4321, 16'h0000, 16'h0000, 16'h0876, 1'b0);
        reset_mid_wait();
        apply_stimulus(4'b0100, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b0);
        apply_stimulus(4'b0001, 16'h00A3, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        for (int b = 0; b < 120; b++) begin
            mask = $urandom_range(1, 15);
            apply_stimulus(4'(mask), rand_word(), rand_word(), rand_word(), rand_word(), 1'b1);
        end

        repeat (5) @(negedge clk);
        check_output("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd2bin_arbiter.md
BCD2BIN_ARBITER -- requirements
Module: bcd2bin_arbiter

Interface
REQ-001 Parameter: W, default 14, binary result width; it SHALL match the shared bcd2bin converter.
REQ-002 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester conversion request; bit i belongs to requester i.
REQ-005 Port: bcd_in  input  64  four packed 16-bit BCD words; requester i uses bits [16i+15:16i], with digit 0 in the low nibble.
REQ-006 Port: ack  output  4  one-cycle, one-hot completion pulse to the served requester.
REQ-007 Port: err  output  4  one-cycle, one-hot rejection pulse; present only with BCD2BIN_ARB_CHECK_EN.
REQ-008 Port: grant  output  4  one-hot; identifies the requester owning the converter from selection until its ack or err.
REQ-009 Port: bin_out  output  W  result register; valid in the ack cycle and held until the next result.
REQ-010 Port: conv_start, conv_bcd0..conv_bcd3  output  1 / 4 each  drive the converter's start input and its four digit inputs.
REQ-011 Port: conv_ready, conv_done_tick, conv_bin  input  1 / 1 / W  the converter's ready, done_tick and bin outputs.

Function
REQ-012 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, DONE.
REQ-013 IDLE -> LAUNCH SHALL occur when conv_ready=1 and req!=0.
  - Selection: round-robin, starting at pointer ptr[1:0].
  - On selection: set grant, and latch the selected 16-bit word into the conv_bcd registers.
REQ-014 If req!=0 but conv_ready=0, the block SHALL stay in IDLE with grant=0.
REQ-015 LAUNCH SHALL assert conv_start for exactly one cycle, then go to WAIT.
REQ-016 conv_start SHALL be 0 in every other state.
REQ-017 WAIT SHALL hold until conv_done_tick=1; in that cycle it SHALL latch conv_bin into bin_out and go to DONE.
REQ-018 DONE SHALL, for one cycle:
  - pulse ack[g], where g is the granted index;
  - clear grant;
  - set ptr to g+1 modulo 4 (wrapping 3->0);
  - return to IDLE.
REQ-019 Minimum latency from req sampled in IDLE to ack SHALL be 3 cycles plus the converter latency (start to done_tick).
REQ-020 Requesters SHALL hold req and bcd_in until ack.
  - Changes to bcd_in after selection SHALL NOT affect the conversion.
  - Deasserting req after selection SHALL NOT abort the conversion; ack is still pulsed.
REQ-021 A requester SHALL NOT be served twice in a row while any other req bit is set.
REQ-022 conv_done_tick outside WAIT SHALL be ignored.
REQ-023 conv_bcd registers SHALL hold their value between conversions.
REQ-024 At most one bit of ack|err SHALL be high in any cycle.

Reset
REQ-025 While reset=1, the block SHALL immediately force, regardless of clk:
  - state=IDLE, ptr=0;
  - grant=0, ack=0, err=0, conv_start=0;
  - bin_out=0, conv_bcd0..3=0.
REQ-026 A reset asserted during LAUNCH or WAIT SHALL abandon the transaction: no ack, and conv_done_tick is ignored after release until a new LAUNCH.

Configuration
REQ-027 Macro BCD2BIN_ARB_CHECK_EN defined: in IDLE, a selected word containing any nibble > 9 SHALL take the error path.
  - Path: go to DONE, pulse err[g] instead of ack[g], and advance ptr.
  - conv_start SHALL NOT be asserted and bin_out SHALL be unchanged.
REQ-028 Macro BCD2BIN_ARB_CHECK_EN undefined: no digit checking is performed.
  - The err port SHALL still exist and be tied to 0.
  - Every selected word SHALL be passed to the converter unchanged.

Verification
REQ-029 req=0001, bcd_in[15:0]=0x0019 -> grant=0001, one conv_start pulse, ack=0001, bin_out=19.
REQ-030 req=1111, words 0x0001/0x0010/0x0100/0x9999 held -> acks in order 0,1,2,3; bin_out=1,10,100,9999 (0x270F).
REQ-031 After serving requester 1, req=0011 -> requester 0 is served before requester 1 again.
  - Then req=1001 with ptr=3 -> requester 3 first, then 0 (wrap).
REQ-032 Assert reset mid-WAIT, then release -> ack=0, grant=0, bin_out=0.
  - A late conv_done_tick produces no ack.
  - The next req=0100 is served normally.
REQ-033 With BCD2BIN_ARB_CHECK_EN, req=0001, bcd_in[15:0]=0x00A3 -> err=0001, no conv_start, bin_out unchanged.
  - Without the macro, the same stimulus yields a conv_start pulse and an ack pulse.
